math_solver: RTL and testbench

Infix expression evaluator for the stack-based ALU subsystem. Converts a fixed-length infix token array to postfix (shunting-yard), then evaluates the postfix array on an internal value stack. It exposes the final result, the postfix array and the per-cycle stack-ALU operation taps for debug.

---
 rtl/math_solver.sv | 190 +++++++++++++++++++
 tb/tb_math_solver.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/math_solver.sv
// Infix expression evaluator: shunting-yard conversion to postfix, then postfix
// evaluation on a value stack, one token action per clock.
module math_solver #(
  parameter int N = 13,
  parameter int W = 16
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic [1:0][N-1:0][W-1:0] infix,
  output logic [W-1:0]             result,
  output logic [1:0][N-1:0][W-1:0] postfix,
  output logic [W-1:0]             input_data,
  output logic [2:0]               opcode,
  output logic [W-1:0]             first,
  output logic [W-1:0]             second,
  output logic [W-1:0]             output_data,
  output logic                     done
);
  localparam int IW = $clog2(N + 1);
  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] NI  = IW'(N);
  localparam logic [IW-1:0] ONE = IW'(1);

  localparam logic [1:0] S_CONVERT = 2'd0, S_FLUSH = 2'd1, S_EVAL = 2'd2, S_DONE = 2'd3;
  localparam logic [2:0] OP_NOP = 3'b000, OP_ADD = 3'b001, OP_SUB = 3'b010,
                         OP_MUL = 3'b011, OP_PUSH = 3'b100;
  localparam logic [W-1:0] SYM_LP = W'(40), SYM_RP = W'(41), SYM_MUL = W'(42),
                           SYM_ADD = W'(43), SYM_SUB = W'(45);
  localparam logic [W-1:0] KIND_OPND = '0, KIND_SYM = W'(1);
  localparam logic [1:0][N-1:0][W-1:0] PF_PAD = {{N{KIND_SYM}}, {(N*W){1'b0}}};

  function automatic logic is_op(input logic [W-1:0] v);
    return (v == SYM_MUL) || (v == SYM_ADD) || (v == SYM_SUB);
  endfunction

  function automatic logic prec(input logic [W-1:0] v);
    return (v == SYM_MUL);
  endfunction

  logic [1:0]               state_q, state_d;
  logic [IW-1:0]            i_q, i_d, j_q, j_d, osp_q, osp_d, vsp_q, vsp_d, pidx_q, pidx_d;
  logic [N-1:0][W-1:0]      ostk_q, ostk_d, vstk_q, vstk_d;
  logic [1:0][N-1:0][W-1:0] pf_q, pf_d;
  logic [W-1:0]             result_q, result_d, input_data_q, input_data_d;
  logic [W-1:0]             first_q, first_d, second_q, second_d, output_data_q, output_data_d;
  logic [2:0]               opcode_q, opcode_d;
  logic                     done_q, done_d;

  logic [W-1:0]  cur_val, otop, emit_val, emit_kind, pv_val, lhs, rhs, alu;
  logic          cur_sym, cur_end, nxt_end, adv, emit, pv_sym, pv_end, pv_nxt_end;
  logic [IW-1:0] nsp;

  always_comb begin
    state_d = state_q; i_d = i_q; j_d = j_q;
    osp_d = osp_q; vsp_d = vsp_q; pidx_d = pidx_q;
    ostk_d = ostk_q; vstk_d = vstk_q; pf_d = pf_q;
    result_d = result_q; done_d = done_q;
    opcode_d = OP_NOP; input_data_d = '0; first_d = '0; second_d = '0; output_data_d = '0;
    adv = 1'b0; emit = 1'b0; emit_val = '0; emit_kind = KIND_OPND;
    lhs = '0; rhs = '0; alu = '0; nsp = '0;

    cur_val = infix[0][AW'(i_q)];
    cur_sym = (infix[1][AW'(i_q)] != '0);
    cur_end = (i_q >= NI) || (cur_sym && cur_val == '0);
    // Look one slot ahead so the last token action also hands over to the next phase.
    nxt_end = ((i_q + ONE) >= NI) ||
              ((infix[1][AW'(i_q + ONE)] != '0) && (infix[0][AW'(i_q + ONE)] == '0));
    otop    = ostk_q[AW'(osp_q - ONE)];

    pv_val     = pf_q[0][AW'(j_q)];
    pv_sym     = (pf_q[1][AW'(j_q)] != '0);
    pv_end     = (j_q >= NI) || (pv_sym && pv_val == '0);
    pv_nxt_end = ((j_q + ONE) >= NI) ||
                 ((pf_q[1][AW'(j_q + ONE)] != '0) && (pf_q[0][AW'(j_q + ONE)] == '0));

    case (state_q)
      S_CONVERT: begin
        if (cur_end) begin
          state_d = (osp_q == '0) ? S_EVAL : S_FLUSH;
          j_d = '0;
        end else if (!cur_sym) begin
          emit = 1'b1; emit_val = cur_val; adv = 1'b1;
        end else if (cur_val == SYM_LP) begin
          if (osp_q < NI) begin
            ostk_d[AW'(osp_q)] = cur_val; osp_d = osp_q + ONE;
          end
          adv = 1'b1;
        end else if (cur_val == SYM_RP) begin
          if (osp_q == '0) adv = 1'b1;
          else if (otop == SYM_LP) begin
            osp_d = osp_q - ONE; adv = 1'b1;
          end else begin
            emit = 1'b1; emit_val = otop; emit_kind = KIND_SYM; osp_d = osp_q - ONE;
          end
        end else if (is_op(cur_val)) begin
          if (osp_q != '0 && is_op(otop) && prec(otop) >= prec(cur_val)) begin
            emit = 1'b1; emit_val = otop; emit_kind = KIND_SYM; osp_d = osp_q - ONE;
          end else begin
            if (osp_q < NI) begin
              ostk_d[AW'(osp_q)] = cur_val; osp_d = osp_q + ONE;
            end
            adv = 1'b1;
          end
        end else begin
          adv = 1'b1;
        end
        if (adv) begin
          i_d = i_q + ONE;
          if (nxt_end) begin
            state_d = (osp_d == '0) ? S_EVAL : S_FLUSH;
            j_d = '0;
          end
        end
      end
      S_FLUSH: begin
        if (osp_q != '0) begin
          if (otop != SYM_LP) begin
            emit = 1'b1; emit_val = otop; emit_kind = KIND_SYM;
          end
          osp_d = osp_q - ONE;
        end
        if (osp_q <= ONE) begin
          state_d = S_EVAL; j_d = '0;
        end
      end
      S_EVAL: begin
        if (pv_end) begin
          state_d = S_DONE;
        end else begin
          if (!pv_sym) begin
            opcode_d = OP_PUSH; input_data_d = pv_val;
            if (vsp_q < NI) begin
              vstk_d[AW'(vsp_q)] = pv_val; vsp_d = vsp_q + ONE;
            end
          end else if (is_op(pv_val)) begin
            // Missing operands on underflow read as zero.
            lhs = (vsp_q >= IW'(2)) ? vstk_q[AW'(vsp_q - IW'(2))] : '0;
            rhs = (vsp_q >= ONE)    ? vstk_q[AW'(vsp_q - ONE)]    : '0;
            nsp = (vsp_q >= IW'(2)) ? (vsp_q - IW'(2)) : '0;
            case (pv_val)
              SYM_ADD: begin alu = lhs + rhs; opcode_d = OP_ADD; end
              SYM_SUB: begin alu = lhs - rhs; opcode_d = OP_SUB; end
              default: begin alu = lhs * rhs; opcode_d = OP_MUL; end
            endcase
            first_d = lhs; second_d = rhs; output_data_d = alu;
            vstk_d[AW'(nsp)] = alu; vsp_d = nsp + ONE;
          end
          j_d = j_q + ONE;
          if (pv_nxt_end) state_d = S_DONE;
        end
      end
      default: begin
        result_d = (vsp_q == '0) ? '0 : vstk_q[AW'(vsp_q - ONE)];
        done_d = 1'b1;
      end
    endcase

    if (emit && pidx_q < NI) begin
      pf_d[0][AW'(pidx_q)] = emit_val;
      pf_d[1][AW'(pidx_q)] = emit_kind;
      pidx_d = pidx_q + ONE;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_CONVERT;
      i_q <= '0; j_q <= '0; osp_q <= '0; vsp_q <= '0; pidx_q <= '0;
      ostk_q <= '0; vstk_q <= '0; pf_q <= PF_PAD;
      result_q <= '0; input_data_q <= '0; first_q <= '0; second_q <= '0;
      output_data_q <= '0; opcode_q <= OP_NOP; done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q <= i_d; j_q <= j_d; osp_q <= osp_d; vsp_q <= vsp_d; pidx_q <= pidx_d;
      ostk_q <= ostk_d; vstk_q <= vstk_d; pf_q <= pf_d;
      result_q <= result_d; input_data_q <= input_data_d; first_q <= first_d;
      second_q <= second_d; output_data_q <= output_data_d; opcode_q <= opcode_d;
      done_q <= done_d;
    end
  end

  assign result      = result_q;
  assign postfix     = pf_q;
  assign input_data  = input_data_q;
  assign opcode      = opcode_q;
  assign first       = first_q;
  assign second      = second_q;
  assign output_data = output_data_q;
  assign done        = done_q;
endmodule

// File: tb/tb_math_solver.sv
// Bench for math_solver: table of textual expressions with fixed expectations, random
// well-formed expressions against a queue-based reference, and reset corner cases.
module tb_math_solver;
  localparam int N = 13;
  localparam int W = 16;
  typedef logic [1:0][N-1:0][W-1:0] arr_t;
  typedef struct packed { logic [2:0] op; logic [W-1:0] in, a, b, o; } step_t;
  typedef struct { string inf; string pf; logic [W-1:0] res; } vec_t;

  logic CLK = 1'b0, RST_N = 1'b0;
  arr_t infix, postfix;
  logic [W-1:0] result, input_data, first, second, output_data;
  logic [2:0] opcode;
  logic done;

  math_solver #(.N(N), .W(W)) dut (
    .CLK(CLK), .RST_N(RST_N), .infix(infix), .result(result), .postfix(postfix),
    .input_data(input_data), .opcode(opcode), .first(first), .second(second),
    .output_data(output_data), .done(done));

  always #5 CLK = ~CLK;

  int n_cmp = 0, n_bad = 0;
  step_t got[$], m_tr[$];
  arr_t m_pf, pad;
  logic [W-1:0] m_res;
  int m_lat;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_pf(input string nm, input arr_t act, input arr_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic is_op(input logic [W-1:0] v);
    return v == 42 || v == 43 || v == 45;
  endfunction

  function automatic int prec(input logic [W-1:0] v);
    return (v == 42) ? 2 : 1;
  endfunction

  // Space-separated tokens; a lone non-digit character is a symbol.
  function automatic arr_t parse(input string s);
    arr_t a;
    int k, p, q, L, v;
    byte c;
    bit neg;
    a = pad; k = 0; p = 0; L = s.len();
    while (p < L) begin
      if (s.getc(p) == 8'd32) p++;
      else begin
        q = p;
        while (q < L && s.getc(q) != 8'd32) q++;
        c = s.getc(p);
        if (k < N) begin
          if (q - p == 1 && (c < 8'd48 || c > 8'd57)) begin
            a[0][k] = W'(c); a[1][k] = W'(1);
          end else begin
            neg = (c == 8'd45); v = 0;
            for (int r = p + (neg ? 1 : 0); r < q; r++) v = v * 10 + (s.getc(r) - 48);
            a[0][k] = W'(neg ? -v : v); a[1][k] = '0;
          end
          k++;
        end
        p = q;
      end
    end
    return a;
  endfunction

  task automatic model(input arr_t a);
    logic [W-1:0] ops[$], pv[$], st[$];
    bit pk[$];
    logic [W-1:0] v, x, y, o;
    logic [2:0] oc;
    int conv;
    conv = 0; m_tr.delete();
    for (int i = 0; i < N; i++) begin
      v = a[0][i];
      if (a[1][i] != 0 && v == 0) break;
      conv++;
      if (a[1][i] == 0) begin pk.push_back(1'b0); pv.push_back(v); end
      else if (v == 40) ops.push_back(v);
      else if (v == 41) begin
        while (ops.size() > 0 && ops[$] != 40) begin
          pk.push_back(1'b1); pv.push_back(ops.pop_back()); conv++;
        end
        if (ops.size() > 0) void'(ops.pop_back());
      end else if (is_op(v)) begin
        while (ops.size() > 0 && is_op(ops[$]) && prec(ops[$]) >= prec(v)) begin
          pk.push_back(1'b1); pv.push_back(ops.pop_back()); conv++;
        end
        ops.push_back(v);
      end
    end
    m_lat = conv + ops.size();
    while (ops.size() > 0) begin
      v = ops.pop_back();
      if (v != 40) begin pk.push_back(1'b1); pv.push_back(v); end
    end
    m_pf = pad;
    for (int k = 0; k < pv.size() && k < N; k++) begin
      m_pf[0][k] = pv[k]; m_pf[1][k] = pk[k] ? W'(1) : W'(0);
    end
    m_lat += pv.size() + 1;
    foreach (pv[k]) begin
      if (!pk[k]) begin
        st.push_back(pv[k]);
        m_tr.push_back('{3'd4, pv[k], W'(0), W'(0), W'(0)});
      end else begin
        y = (st.size() > 0) ? st.pop_back() : '0;
        x = (st.size() > 0) ? st.pop_back() : '0;
        if (pv[k] == 43) begin o = x + y; oc = 3'd1; end
        else if (pv[k] == 45) begin o = x - y; oc = 3'd2; end
        else begin o = W'(x * y); oc = 3'd3; end
        st.push_back(o);
        m_tr.push_back('{oc, W'(0), x, y, o});
      end
    end
    m_res = (st.size() > 0) ? st[$] : '0;
  endtask

  task automatic chk_reset_state(input string nm);
    chk({nm, "_done"}, 64'(done), 64'd0);
    chk({nm, "_result"}, 64'(result), 64'd0);
    chk({nm, "_opcode"}, 64'(opcode), 64'd0);
    chk({nm, "_taps"}, {input_data, first, second, output_data}, 64'd0);
    chk_pf({nm, "_postfix"}, postfix, pad);
  endtask

  task automatic run(input arr_t a, input bit chk_rst, output int cyc);
    infix = a;
    RST_N = 1'b0;
    #13;
    if (chk_rst) chk_reset_state("reset");
    @(negedge CLK);
    RST_N = 1'b1;
    got.delete(); cyc = 0;
    while (!done && cyc < 300) begin
      @(posedge CLK); #1;
      cyc++;
      if (opcode != 3'd0) got.push_back('{opcode, input_data, first, second, output_data});
    end
    chk("done_timeout", 64'(done), 64'd1);
  endtask

  task automatic check_model(input string nm, input int cyc);
    int bad;
    chk({nm, "_latency"}, 64'(cyc), 64'(m_lat));
    chk({nm, "_result"}, 64'(result), 64'(m_res));
    chk_pf({nm, "_postfix"}, postfix, m_pf);
    chk({nm, "_trace_len"}, 64'(got.size()), 64'(m_tr.size()));
    bad = -1;
    for (int k = 0; k < got.size() && k < m_tr.size(); k++)
      if (bad < 0 && got[k] !== m_tr[k]) bad = k;
    chk({nm, "_trace_first_bad_step"}, 64'(bad), 64'(-1));
  endtask

  vec_t vecs[12];
  arr_t a;
  int cyc, kk[N], vv[N], len, depth, rem;
  bit need, stop;

  initial begin
    for (int t = 0; t < N; t++) begin pad[0][t] = '0; pad[1][t] = W'(1); end
    vecs[0]  = '{"-4 - ( 42 * 43 - ( 41 + 40 ) )", "-4 42 43 * 41 40 + - -", 16'hF93F};
    vecs[1]  = '{"2 + 3 * 4", "2 3 4 * +", 16'd14};
    vecs[2]  = '{"( 2 + 3 ) * 4", "2 3 + 4 *", 16'd20};
    vecs[3]  = '{"7 - 2 - 1", "7 2 - 1 -", 16'd4};
    vecs[4]  = '{"300 * 300", "300 300 *", 16'h5F90};
    vecs[5]  = '{"- 5", "5 -", 16'hFFFB};
    vecs[6]  = '{"5 )", "5", 16'd5};
    vecs[7]  = '{"( ( 1 + 2 )", "1 2 +", 16'd3};
    vecs[8]  = '{"2 * 3 + 4 * 5 - 6", "2 3 * 4 5 * + 6 -", 16'd20};
    vecs[9]  = '{"1 2", "1 2", 16'd2};
    vecs[10] = '{"-32768 - 1", "-32768 1 -", 16'h7FFF};
    vecs[11] = '{"6 / + 2", "6 2 +", 16'd8};

    foreach (vecs[i]) begin
      a = parse(vecs[i].inf);
      model(a);
      run(a, i == 0, cyc);
      chk($sformatf("vec%0d_result", i), 64'(result), 64'(vecs[i].res));
      chk_pf($sformatf("vec%0d_postfix", i), postfix, parse(vecs[i].pf));
      check_model($sformatf("vec%0d", i), cyc);
      if (i == 1) begin
        chk("mul_step_operands", {16'd0, got[3].op, got[3].a, got[3].b, got[3].o},
            {16'd0, 3'd3, 16'd3, 16'd4, 16'd12});
      end
      if (i == 4) begin
        chk("wrap_opcode_seq", {61'(got.size()), got[0].op, got[1].op, got[2].op} ,
            {61'd3, 3'd4, 3'd4, 3'd3});
      end
    end

    // Held in DONE: result stable, no ALU activity.
    repeat (3) @(posedge CLK);
    #1;
    chk("done_hold", {done, opcode, result}, {1'b1, 3'd0, 16'h0008});

    // Full 13-token expression with no PAD.
    a = parse("1 + 2 + 3 + 4 + 5 + 6 + 7");
    model(a);
    run(a, 0, cyc);
    chk("full_result", 64'(result), 64'd28);
    check_model("full", cyc);

    // Reset in the middle of EVAL, then restart.
    a = parse(vecs[0].inf);
    infix = a;
    RST_N = 1'b0; #13;
    @(negedge CLK); RST_N = 1'b1;
    cyc = 0;
    while (opcode == 3'd0 && cyc < 100) begin @(posedge CLK); #1; cyc++; end
    chk("eval_reached", 64'(opcode != 3'd0), 64'd1);
    repeat (2) @(posedge CLK);
    #2 RST_N = 1'b0;
    #1 chk_reset_state("midreset");
    model(a);
    run(a, 0, cyc);
    chk("rerun_result", 64'(result), 64'hF93F);
    check_model("rerun", cyc);

    // Random well-formed expressions.
    for (int r = 0; r < 40; r++) begin
      len = 0; depth = 0; need = 1; stop = 0;
      while (!stop) begin
        rem = N - len;
        if (need) begin
          if (rem >= depth + 5 && $urandom_range(0, 3) == 0) begin
            kk[len] = 1; vv[len] = 40; len++; depth++;
          end else begin
            kk[len] = 0;
            vv[len] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 20));
            len++; need = 0;
          end
        end else if (depth > 0 && $urandom_range(0, 2) == 0) begin
          kk[len] = 1; vv[len] = 41; len++; depth--;
        end else if (rem >= depth + 2 && $urandom_range(0, 5) != 0) begin
          kk[len] = 1;
          case ($urandom_range(0, 2)) 0: vv[len] = 42; 1: vv[len] = 43; default: vv[len] = 45; endcase
          len++; need = 1;
        end else begin
          repeat (depth) begin kk[len] = 1; vv[len] = 41; len++; end
          stop = 1;
        end
      end
      a = pad;
      for (int k = 0; k < len; k++) begin a[0][k] = W'(vv[k]); a[1][k] = W'(kk[k]); end
      model(a);
      run(a, 0, cyc);
      check_model($sformatf("rand%0d", r), cyc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
